// File: rtl/morse_symbol_sequencer_pkg.sv
// Shared definitions for the Morse symbol sequencer.
//   state_t        : sequencer FSM encoding
//   MAX_SYMBOLS    : dots/dashes held per letter (the LUT covers 1..5)
//   ASCII_UNKNOWN  : character emitted for unmapped or overflowed letters
package morse_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COLLECT   = 2'd1,
      WAIT_WORD = 2'd2
   } state_t;

   localparam int         MAX_SYMBOLS   = 5;
   localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

endpackage

// File: rtl/morse_symbol_sequencer_if.sv
// Symbol-in / character-out bundle of the Morse symbol sequencer.
//   btn_in      : raw button level, 1 = pressed
//   sym_valid   : one-cycle pulse, a press was classified
//   sym_is_long : qualifies sym_valid, 1 = dash, 0 = dot
//   char_valid  : one-cycle pulse, char_code/char_err updated
//   char_code   : ASCII of the last letter, held between pulses
//   char_err    : last letter unmapped or overflowed, held between pulses
//   word_valid  : one-cycle pulse, word gap elapsed
//   busy        : sequencer is not idle
// slave = the sequencer, master = the upstream/downstream environment.
interface morse_symbol_sequencer_if;

   logic       btn_in;
   logic       sym_valid;
   logic       sym_is_long;
   logic       char_valid;
   logic [7:0] char_code;
   logic       char_err;
   logic       word_valid;
   logic       busy;

   modport slave (
      input  btn_in, sym_valid, sym_is_long,
      output char_valid, char_code, char_err, word_valid, busy
   );

   modport master (
      output btn_in, sym_valid, sym_is_long,
      input  char_valid, char_code, char_err, word_valid, busy
   );

endinterface

// File: rtl/morse_symbol_sequencer_lut.sv
// Morse pattern to ASCII decoder, purely combinational.
//   i_sym_cnt : number of symbols in the letter (1..5 valid)
//   i_pattern : symbols, first one in bit 0, 1 = dash
//   o_err     : pattern has no A-Z/0-9 mapping
//   o_ascii   : decoded character, ASCII_UNKNOWN when o_err
module morse_lut
   import morse_pkg::*;
(
   input  logic [2:0] i_sym_cnt,
   input  logic [4:0] i_pattern,
   output logic       o_err,
   output logic [7:0] o_ascii
);

   logic [4:0] w_key;

   // Reorder so the first symbol is the MSB of the used field; the table
   // below then reads left to right like the Morse chart.
   always_comb begin
      w_key = '0;
      case (i_sym_cnt)
         3'd1:    w_key = {4'b0, i_pattern[0]};
         3'd2:    w_key = {3'b0, i_pattern[0], i_pattern[1]};
         3'd3:    w_key = {2'b0, i_pattern[0], i_pattern[1], i_pattern[2]};
         3'd4:    w_key = {1'b0, i_pattern[0], i_pattern[1], i_pattern[2], i_pattern[3]};
         3'd5:    w_key = {i_pattern[0], i_pattern[1], i_pattern[2], i_pattern[3], i_pattern[4]};
         default: w_key = '0;
      endcase
   end

   always_comb begin
      o_ascii = ASCII_UNKNOWN;
      case ({i_sym_cnt, w_key})
         {3'd2, 5'b00001}: o_ascii = 8'h41; // A .-
         {3'd4, 5'b01000}: o_ascii = 8'h42; // B -...
         {3'd4, 5'b01010}: o_ascii = 8'h43; // C -.-.
         {3'd3, 5'b00100}: o_ascii = 8'h44; // D -..
         {3'd1, 5'b00000}: o_ascii = 8'h45; // E .
         {3'd4, 5'b00010}: o_ascii = 8'h46; // F ..-.
         {3'd3, 5'b00110}: o_ascii = 8'h47; // G --.
         {3'd4, 5'b00000}: o_ascii = 8'h48; // H ....
         {3'd2, 5'b00000}: o_ascii = 8'h49; // I ..
         {3'd4, 5'b00111}: o_ascii = 8'h4A; // J .---
         {3'd3, 5'b00101}: o_ascii = 8'h4B; // K -.-
         {3'd4, 5'b00100}: o_ascii = 8'h4C; // L .-..
         {3'd2, 5'b00011}: o_ascii = 8'h4D; // M --
         {3'd2, 5'b00010}: o_ascii = 8'h4E; // N -.
         {3'd3, 5'b00111}: o_ascii = 8'h4F; // O ---
         {3'd4, 5'b00110}: o_ascii = 8'h50; // P .--.
         {3'd4, 5'b01101}: o_ascii = 8'h51; // Q --.-
         {3'd3, 5'b00010}: o_ascii = 8'h52; // R .-.
         {3'd3, 5'b00000}: o_ascii = 8'h53; // S ...
         {3'd1, 5'b00001}: o_ascii = 8'h54; // T -
         {3'd3, 5'b00001}: o_ascii = 8'h55; // U ..-
         {3'd4, 5'b00001}: o_ascii = 8'h56; // V ...-
         {3'd3, 5'b00011}: o_ascii = 8'h57; // W .--
         {3'd4, 5'b01001}: o_ascii = 8'h58; // X -..-
         {3'd4, 5'b01011}: o_ascii = 8'h59; // Y -.--
         {3'd4, 5'b01100}: o_ascii = 8'h5A; // Z --..
         {3'd5, 5'b11111}: o_ascii = 8'h30; // 0 -----
         {3'd5, 5'b01111}: o_ascii = 8'h31; // 1 .----
         {3'd5, 5'b00111}: o_ascii = 8'h32; // 2 ..---
         {3'd5, 5'b00011}: o_ascii = 8'h33; // 3 ...--
         {3'd5, 5'b00001}: o_ascii = 8'h34; // 4 ....-
         {3'd5, 5'b00000}: o_ascii = 8'h35; // 5 .....
         {3'd5, 5'b10000}: o_ascii = 8'h36; // 6 -....
         {3'd5, 5'b11000}: o_ascii = 8'h37; // 7 --...
         {3'd5, 5'b11100}: o_ascii = 8'h38; // 8 ---..
         {3'd5, 5'b11110}: o_ascii = 8'h39; // 9 ----.
         default:          o_ascii = ASCII_UNKNOWN;
      endcase
   end

   // '?' is never a mapped character, so it doubles as the miss flag.
   assign o_err = (o_ascii == ASCII_UNKNOWN);

endmodule

// File: rtl/morse_symbol_sequencer.sv
// Morse symbol sequencer: collects classified dots/dashes into a letter,
// closes the letter after LETTER_GAP_TH idle cycles (one ASCII char out)
// and the word after WORD_GAP_TH idle cycles (word_valid pulse).
//   clk   : system clock
//   rst_n : asynchronous reset, active low
//   bus   : symbol inputs and character/word outputs (slave modport)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no letter in progress, gap counter held at 0
// COLLECT   | letter in progress, waiting for letter gap or next symbol
// WAIT_WORD | letter emitted, waiting for word gap or next letter
module morse_symbol_sequencer
   import morse_pkg::*;
#(
   parameter int unsigned LETTER_GAP_TH = 30000,
   parameter int unsigned WORD_GAP_TH   = 70000,
   parameter int unsigned CNT_W         = 17
) (
   input logic                     clk,
   input logic                     rst_n,
   morse_symbol_sequencer_if.slave bus
);

   localparam logic [CNT_W-1:0] LETTER_TC = CNT_W'(LETTER_GAP_TH - 1);
   localparam logic [CNT_W-1:0] WORD_TC   = CNT_W'(WORD_GAP_TH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t           r_state,      w_state_nxt;
   logic [CNT_W-1:0] r_gap_cnt,    w_gap_cnt_nxt;
   logic [2:0]       r_sym_cnt,    w_sym_cnt_nxt;
   logic [4:0]       r_pattern,    w_pattern_nxt;
   logic             r_ovf,        w_ovf_nxt;
   logic [7:0]       r_char_code,  w_char_code_nxt;
   logic             r_char_err,   w_char_err_nxt;
   logic             r_char_valid, w_char_valid_nxt;
   logic             r_word_valid, w_word_valid_nxt;

   logic             w_gap_run;
   logic             w_lut_err;
   logic [7:0]       w_lut_ascii;

   morse_lut u_lut (
      .i_sym_cnt (r_sym_cnt),
      .i_pattern (r_pattern),
      .o_err     (w_lut_err),
      .o_ascii   (w_lut_ascii)
   );

   // Any button activity or new symbol restarts the idle-gap measurement.
   assign w_gap_run = !(bus.btn_in || bus.sym_valid);

   always_comb begin
      w_state_nxt      = r_state;
      w_gap_cnt_nxt    = r_gap_cnt;
      w_sym_cnt_nxt    = r_sym_cnt;
      w_pattern_nxt    = r_pattern;
      w_ovf_nxt        = r_ovf;
      w_char_code_nxt  = r_char_code;
      w_char_err_nxt   = r_char_err;
      w_char_valid_nxt = 1'b0;
      w_word_valid_nxt = 1'b0;

      // Symbol storage is common to all states: sym_cnt is already 0 in
      // IDLE and WAIT_WORD, so the symbol lands as the first of a letter.
      if (bus.sym_valid) begin
         if (r_sym_cnt < 3'(MAX_SYMBOLS)) begin
            w_pattern_nxt[r_sym_cnt] = bus.sym_is_long;
            w_sym_cnt_nxt            = r_sym_cnt + 3'd1;
         end else begin
            w_ovf_nxt = 1'b1;
         end
      end

      if (r_state == IDLE || !w_gap_run) begin
         w_gap_cnt_nxt = '0;
      end else if (r_gap_cnt != CNT_MAX) begin
         w_gap_cnt_nxt = r_gap_cnt + 1'b1;
      end

      case (r_state)
         IDLE: begin
            if (bus.sym_valid) begin
               w_state_nxt = COLLECT;
            end
         end
         COLLECT: begin
            if (w_gap_run && r_gap_cnt == LETTER_TC) begin
               w_char_valid_nxt = 1'b1;
               w_char_err_nxt   = w_lut_err || r_ovf;
               w_char_code_nxt  = (w_lut_err || r_ovf) ? ASCII_UNKNOWN : w_lut_ascii;
               w_sym_cnt_nxt    = '0;
               w_pattern_nxt    = '0;
               w_ovf_nxt        = 1'b0;
               w_state_nxt      = WAIT_WORD;
            end
         end
         WAIT_WORD: begin
            if (bus.sym_valid) begin
               w_state_nxt = COLLECT;
            end else if (w_gap_run && r_gap_cnt == WORD_TC) begin
               w_word_valid_nxt = 1'b1;
               w_gap_cnt_nxt    = '0;
               w_state_nxt      = IDLE;
            end
         end
         default: begin
            w_state_nxt   = IDLE;
            w_gap_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_gap_cnt    <= '0;
         r_sym_cnt    <= '0;
         r_pattern    <= '0;
         r_ovf        <= 1'b0;
         r_char_code  <= 8'h00;
         r_char_err   <= 1'b0;
         r_char_valid <= 1'b0;
         r_word_valid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_gap_cnt    <= w_gap_cnt_nxt;
         r_sym_cnt    <= w_sym_cnt_nxt;
         r_pattern    <= w_pattern_nxt;
         r_ovf        <= w_ovf_nxt;
         r_char_code  <= w_char_code_nxt;
         r_char_err   <= w_char_err_nxt;
         r_char_valid <= w_char_valid_nxt;
         r_word_valid <= w_word_valid_nxt;
      end
   end

   assign bus.char_valid = r_char_valid;
   assign bus.char_code  = r_char_code;
   assign bus.char_err   = r_char_err;
   assign bus.word_valid = r_word_valid;
   assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_morse_symbol_sequencer.sv
module tb_morse_symbol_sequencer;

   localparam int LG = 100;
   localparam int WG = 300;

   typedef struct {
      int         len;
      logic [7:0] syms;
      logic [7:0] code;
      logic       err;
   } vec_t;

   typedef struct {
      int         cyc;
      logic [7:0] code;
      logic       err;
   } exp_char_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   errors;

   exp_char_t q_char[$];
   int        q_word[$];
   exp_char_t mon_e;
   int        mon_w;

   vec_t tbl[10];

   morse_symbol_sequencer_if bus ();

   morse_symbol_sequencer #(
      .LETTER_GAP_TH (LG),
      .WORD_GAP_TH   (WG),
      .CNT_W         (17)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard side: every emitted char/word must match the head of its queue.
   always @(negedge clk) begin
      if (bus.char_valid || bus.word_valid) begin
         chk("char_word_exclusive", {31'b0, bus.char_valid && bus.word_valid}, 32'd0);
      end
      if (bus.char_valid) begin
         if (q_char.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL char_unexpected: char_valid at cycle %0d code %0h, expected none", cyc, bus.char_code);
         end else begin
            mon_e = q_char.pop_front();
            chk("char_cycle", cyc, mon_e.cyc);
            chk("char_code", {24'b0, bus.char_code}, {24'b0, mon_e.code});
            chk("char_err", {31'b0, bus.char_err}, {31'b0, mon_e.err});
         end
      end
      if (bus.word_valid) begin
         if (q_word.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL word_unexpected: word_valid at cycle %0d, expected none", cyc);
         end else begin
            mon_w = q_word.pop_front();
            chk("word_cycle", cyc, mon_w);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   // Press, release with classifier pulse, short idle. ec = sampling edge.
   task automatic send_sym(input logic is_long, output int ec);
      bus.btn_in = 1'b1;
      repeat (3) tick();
      bus.btn_in      = 1'b0;
      bus.sym_valid   = 1'b1;
      bus.sym_is_long = is_long;
      tick();
      ec              = cyc;
      bus.sym_valid   = 1'b0;
      bus.sym_is_long = 1'($urandom_range(0, 1));
      repeat (5) tick();
   endtask

   task automatic send_letter(input int len, input logic [7:0] syms, output int last);
      for (int i = 0; i < len; i++) begin
         send_sym(syms[i[2:0]], last);
      end
   endtask

   task automatic push_char(input int c, input logic [7:0] code, input logic err);
      exp_char_t e;
      e.cyc  = c;
      e.code = code;
      e.err  = err;
      q_char.push_back(e);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_char_valid"}, {31'b0, bus.char_valid}, 32'd0);
      chk({tag, "_char_code"}, {24'b0, bus.char_code}, 32'd0);
      chk({tag, "_char_err"}, {31'b0, bus.char_err}, 32'd0);
      chk({tag, "_word_valid"}, {31'b0, bus.word_valid}, 32'd0);
      chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
   endtask

   initial begin
      int last;
      int t1;
      int m;

      checks = 0;
      errors = 0;
      // symbol i in bit i, 1 = dash
      tbl[0] = '{1, 8'h00, 8'h45, 1'b0}; // E .
      tbl[1] = '{1, 8'h01, 8'h54, 1'b0}; // T -
      tbl[2] = '{4, 8'h0B, 8'h51, 1'b0}; // Q --.-
      tbl[3] = '{4, 8'h0D, 8'h59, 1'b0}; // Y -.--
      tbl[4] = '{4, 8'h01, 8'h42, 1'b0}; // B -...
      tbl[5] = '{5, 8'h1F, 8'h30, 1'b0}; // 0 -----
      tbl[6] = '{5, 8'h0F, 8'h39, 1'b0}; // 9 ----.
      tbl[7] = '{5, 8'h1E, 8'h31, 1'b0}; // 1 .----
      tbl[8] = '{5, 8'h00, 8'h35, 1'b0}; // 5 .....
      tbl[9] = '{6, 8'h00, 8'h3F, 1'b1}; // six dots, overflow

      rst_n           = 1'b0;
      bus.btn_in      = 1'b0;
      bus.sym_valid   = 1'b0;
      bus.sym_is_long = 1'b0;
      repeat (3) tick();
      chk_idle_outputs("reset");
      rst_n = 1'b1;
      tick();

      // dot, dash -> A; busy drops with the word pulse
      send_sym(1'b0, last);
      send_sym(1'b1, last);
      push_char(last + LG, 8'h41, 1'b0);
      q_word.push_back(last + WG);
      wait_until(last + WG - 1);
      chk("busy_before_word", {31'b0, bus.busy}, 32'd1);
      tick();
      chk("busy_after_word", {31'b0, bus.busy}, 32'd0);
      wait_until(last + WG + 10);

      // table of independent single-letter words
      for (int k = 0; k < 10; k++) begin
         send_letter(tbl[k].len, tbl[k].syms, last);
         push_char(last + LG, tbl[k].code, tbl[k].err);
         q_word.push_back(last + WG);
         wait_until(last + WG + 10);
      end

      // unmapped 5-symbol pattern ..--.
      send_letter(5, 8'h0C, last);
      push_char(last + LG, 8'h3F, 1'b1);
      q_word.push_back(last + WG);
      wait_until(last + WG + 10);

      // S, 150-cycle gap, O inside one word
      send_letter(3, 8'h00, t1);
      push_char(t1 + LG, 8'h53, 1'b0);
      wait_until(t1 + 150);
      send_letter(3, 8'h07, last);
      push_char(last + LG, 8'h4F, 1'b0);
      q_word.push_back(last + WG);
      wait_until(last + WG + 10);

      // button held after a dot postpones the letter close
      send_sym(1'b0, last);
      bus.btn_in = 1'b1;
      repeat (500) tick();
      m = cyc;
      bus.btn_in = 1'b0;
      push_char(m + LG, 8'h45, 1'b0);
      q_word.push_back(m + WG);
      wait_until(m + WG + 10);

      // second dot arrives exactly on the letter threshold cycle
      send_sym(1'b0, last);
      wait_until(last + LG - 1);
      bus.sym_valid   = 1'b1;
      bus.sym_is_long = 1'b0;
      tick();
      bus.sym_valid = 1'b0;
      push_char(last + 2 * LG, 8'h49, 1'b0);
      q_word.push_back(last + LG + WG);
      wait_until(last + LG + WG + 10);

      // reset mid-letter: char_code is nonzero beforehand
      send_sym(1'b0, last);
      send_sym(1'b0, last);
      rst_n = 1'b0;
      #1;
      chk_idle_outputs("rst_async");
      repeat (3) begin
         tick();
         chk("rst_hold_busy", {31'b0, bus.busy}, 32'd0);
      end
      rst_n = 1'b1;
      tick();
      chk_idle_outputs("rst_release");
      m = cyc;
      wait_until(m + 400);
      chk("rst_post_busy", {31'b0, bus.busy}, 32'd0);

      chk("char_queue_empty", q_char.size(), 32'd0);
      chk("word_queue_empty", q_word.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
